// File: rtl/masked_logic_hpc3_vec_if.sv
// Bundle for the masked logic vector: operands, randomness, op select and result.
// Optional rnd_cnt port appears when MASKED_LOGIC_RND_CNT_EN is defined.
interface masked_logic_hpc3_vec_if #(
    parameter int SECURITY_ORDER = 1,
    parameter int WIDTH          = 1
);
    localparam int N = SECURITY_ORDER + 1;

    logic                              in_valid;
    logic [1:0]                        op;
    logic [WIDTH*N-1:0]                a;
    logic [WIDTH*N-1:0]                b;
    logic [WIDTH*SECURITY_ORDER*N-1:0] r;
    logic                              out_valid;
    logic [WIDTH*N-1:0]                c;
`ifdef MASKED_LOGIC_RND_CNT_EN
    logic [31:0]                       rnd_cnt;

    modport master (output in_valid, op, a, b, r, input out_valid, c, rnd_cnt);
    modport slave  (input in_valid, op, a, b, r, output out_valid, c, rnd_cnt);
`else
    modport master (output in_valid, op, a, b, r, input out_valid, c);
    modport slave  (input in_valid, op, a, b, r, output out_valid, c);
`endif
endinterface

// File: rtl/masked_logic_hpc3_vec.sv
// W-lane HPC3-masked AND/NAND/OR/NOR gate with valid tracking and optional output stage.
// Define MASKED_LOGIC_RND_CNT_EN to add a saturating accepted-transaction counter (rnd_cnt).
module masked_logic_hpc3_vec #(
    parameter int SECURITY_ORDER = 1,
    parameter int WIDTH          = 1,
    parameter int PIPELINE       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    masked_logic_hpc3_vec_if.slave bus
);
    localparam int D  = SECURITY_ORDER;
    localparam int N  = D + 1;
    localparam int H  = D * N / 2;
    localparam int NN = N * N;
    localparam int RL = D * N;

    logic [1:0]         r_op;
    logic               r_vld1;
    logic               w_inv;
    logic               w_or;
    logic [WIDTH*N-1:0] w_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_op <= bus.op;
            end
        end
    end

    // OR/NOR are AND with share-0 operand inversion; NAND/OR need share-0 output inversion
    assign w_or  = bus.op[1];
    assign w_inv = r_op[0] ^ r_op[1];

    generate
        for (genvar gl = 0; gl < WIDTH; gl++) begin : g_lane
            logic [N-1:0]  w_a;
            logic [N-1:0]  w_b;
            logic [NN-1:0] w_u;
            logic [NN-1:0] w_v;
            logic [NN-1:0] r_u;
            logic [NN-1:0] r_v;

            assign w_a = bus.a[gl*N +: N] ^ {{(N-1){1'b0}}, w_or};
            assign w_b = bus.b[gl*N +: N] ^ {{(N-1){1'b0}}, w_or};

            for (genvar gi = 0; gi < N; gi++) begin : g_row
                for (genvar gj = 0; gj < N; gj++) begin : g_col
                    if (gi == gj) begin : g_diag
                        assign w_u[gi*N+gj] = w_a[gi] & w_b[gi];
                        assign w_v[gi*N+gj] = 1'b0;
                    end else begin : g_cross
                        localparam int LO = (gi < gj) ? gi : gj;
                        localparam int HI = (gi < gj) ? gj : gi;
                        localparam int K  = LO * D - (LO * (LO - 1)) / 2 + (HI - LO - 1);
                        logic w_r0;
                        logic w_r1;
                        assign w_r0 = bus.r[gl*RL + K];
                        assign w_r1 = bus.r[gl*RL + H + K];
                        // share j of b is blinded before it meets share i of a
                        assign w_u[gi*N+gj] = w_a[gi] & (w_b[gj] ^ w_r0);
                        assign w_v[gi*N+gj] = (~w_a[gi] & w_r0) ^ w_r1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_u <= '0;
                    r_v <= '0;
                end else if (bus.in_valid) begin
                    r_u <= w_u;
                    r_v <= w_v;
                end
            end

            for (genvar gi = 0; gi < N; gi++) begin : g_cmp
                assign w_c[gl*N+gi] = (^r_u[gi*N +: N]) ^ (^r_v[gi*N +: N])
                                    ^ ((gi == 0) ? w_inv : 1'b0);
            end
        end

        if (PIPELINE != 0) begin : g_pipe
            logic               r_vld2;
            logic [WIDTH*N-1:0] r_c;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld2 <= 1'b0;
                    r_c    <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_c <= w_c;
                    end
                end
            end

            assign bus.out_valid = r_vld2;
            assign bus.c         = r_c;
        end else begin : g_comb
            assign bus.out_valid = r_vld1;
            assign bus.c         = w_c;
        end
    endgenerate

`ifdef MASKED_LOGIC_RND_CNT_EN
    logic [31:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.in_valid && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign bus.rnd_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_masked_logic_hpc3_vec.sv
// Scoreboard bench: d=1/W=1/latency-1 instance for the known-answer vectors and
// a d=2/W=4/latency-2 instance for random back-to-back traffic and reset abort.
module tb_masked_logic_hpc3_vec;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        logic [3:0] unm;
        int         cyc;
        logic       chk_sh;
        logic [1:0] sh;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    masked_logic_hpc3_vec_if #(.SECURITY_ORDER(1), .WIDTH(1)) bus0();
    masked_logic_hpc3_vec_if #(.SECURITY_ORDER(2), .WIDTH(4)) bus1();

    masked_logic_hpc3_vec #(.SECURITY_ORDER(1), .WIDTH(1), .PIPELINE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    masked_logic_hpc3_vec #(.SECURITY_ORDER(2), .WIDTH(4), .PIPELINE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: recombine shares by XOR, apply the plain Boolean gate per lane
    function automatic logic [3:0] unmask(input logic [11:0] v, input int n, input int w);
        logic [3:0] res;
        res = '0;
        for (int l = 0; l < w; l++)
            for (int j = 0; j < n; j++)
                res[l] = res[l] ^ v[l*n+j];
        return res;
    endfunction

    function automatic logic [3:0] ref_gate(input logic [1:0] op, input logic [11:0] a,
                                            input logic [11:0] b, input int n, input int w);
        logic [3:0] ua;
        logic [3:0] ub;
        logic [3:0] res;
        ua = unmask(a, n, w);
        ub = unmask(b, n, w);
        case (op)
            2'd0:    res = ua & ub;
            2'd1:    res = ~(ua & ub);
            2'd2:    res = ua | ub;
            default: res = ~(ua | ub);
        endcase
        for (int l = w; l < 4; l++) res[l] = 1'b0;
        return res;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus0.out_valid) begin
            if (q0.size() == 0) begin
                chk("dut0_spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                $display("[TB] dut0 txn issued@%0d seen@%0d c=%b exp_unm=%b", e.cyc, cyc, bus0.c, e.unm[0]);
                chk("dut0_latency", 32'(cyc - e.cyc), 32'd1);
                chk("dut0_unmasked", 32'(unmask({10'b0, bus0.c}, 2, 1)), 32'(e.unm));
                if (e.chk_sh) chk("dut0_shares", 32'(bus0.c), 32'(e.sh));
            end
        end
        if (rst_n && bus1.out_valid) begin
            if (q1.size() == 0) begin
                chk("dut1_spurious_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                $display("[TB] dut1 txn issued@%0d seen@%0d c=%h exp_unm=%b", e.cyc, cyc, bus1.c, e.unm);
                chk("dut1_latency", 32'(cyc - e.cyc), 32'd2);
                chk("dut1_unmasked", 32'(unmask(bus1.c, 3, 4)), 32'(e.unm));
            end
        end
    end

    task automatic send0(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] r, input logic chk_sh, input logic [1:0] sh);
        exp_t e;
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.op = op; bus0.a = a; bus0.b = b; bus0.r = r;
        e.unm = ref_gate(op, {10'b0, a}, {10'b0, b}, 2, 1);
        e.cyc = cyc; e.chk_sh = chk_sh; e.sh = sh;
        q0.push_back(e);
    endtask

    task automatic send1(output logic [3:0] unm);
        exp_t e;
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.op = 2'($urandom_range(3, 0));
        bus1.a  = 12'($urandom);
        bus1.b  = 12'($urandom);
        bus1.r  = 24'($urandom);
        e.unm = ref_gate(bus1.op, bus1.a, bus1.b, 3, 4);
        e.cyc = cyc; e.chk_sh = 1'b0; e.sh = 2'b00;
        q1.push_back(e);
        unm = e.unm;
    endtask

    // Idle cycle with garbage on the data inputs, which must be ignored
    task automatic idle_cycle();
        @(negedge clk);
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        bus0.op = 2'($urandom); bus0.a = 2'($urandom); bus0.b = 2'($urandom); bus0.r = 2'($urandom);
        bus1.op = 2'($urandom); bus1.a = 12'($urandom); bus1.b = 12'($urandom); bus1.r = 24'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (q0.size() != 0 || q1.size() != 0); k++) idle_cycle();
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] last0;
        logic [3:0] last1;
        logic [3:0] tmp;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.op = '0; bus0.a = '0; bus0.b = '0; bus0.r = '0;
        bus1.in_valid = 1'b0; bus1.op = '0; bus1.a = '0; bus1.b = '0; bus1.r = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid0", 32'(bus0.out_valid), 32'd0);
        chk("rst_c0", 32'(bus0.c), 32'd0);
        chk("rst_valid1", 32'(bus1.out_valid), 32'd0);
        chk("rst_c1", 32'(bus1.c), 32'd0);
        rst_n = 1'b1;

        // Known-answer vectors: a=(1,0), b=(1,1), r=1, r'=0
        send0(2'd0, 2'b01, 2'b11, 2'b01, 1'b1, 2'b11); idle_cycle();
        send0(2'd1, 2'b01, 2'b11, 2'b01, 1'b1, 2'b10); idle_cycle();
        send0(2'd2, 2'b01, 2'b11, 2'b01, 1'b1, 2'b10); idle_cycle();
        send0(2'd3, 2'b01, 2'b11, 2'b01, 1'b1, 2'b11); idle_cycle();

        last0 = '0;
        for (int t = 0; t < 20; t++) begin
            send0(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'b0, 2'b00);
            last0 = q0[q0.size()-1].unm;
        end
        drain();
        for (int t = 0; t < 5; t++) begin
            idle_cycle();
            chk("idle_valid0", 32'(bus0.out_valid), 32'd0);
            chk("idle_hold0", 32'(unmask({10'b0, bus0.c}, 2, 1)), 32'(last0));
        end

        last1 = '0;
        for (int t = 0; t < 200; t++) begin
            send1(tmp);
            last1 = tmp;
        end
        drain();
        for (int t = 0; t < 5; t++) begin
            idle_cycle();
            chk("idle_valid1", 32'(bus1.out_valid), 32'd0);
            chk("idle_hold1", 32'(unmask(bus1.c, 3, 4)), 32'(last1));
        end

        // Reset one cycle after acceptance: transaction must vanish
        send1(tmp);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        rst_n = 1'b0;
        q1.delete();
        #1;
        chk("abort_c1", 32'(bus1.c), 32'd0);
        chk("abort_valid1", 32'(bus1.out_valid), 32'd0);
        chk("abort_c0", 32'(bus0.c), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            idle_cycle();
            chk("abort_no_valid1", 32'(bus1.out_valid), 32'd0);
        end

`ifdef MASKED_LOGIC_RND_CNT_EN
        chk("cnt_after_rst", bus1.rnd_cnt, 32'd0);
        for (int t = 0; t < 7; t++) send1(tmp);
        for (int t = 0; t < 3; t++) idle_cycle();
        chk("cnt_seven", bus1.rnd_cnt, 32'd7);
        drain();
        @(negedge clk);
        force dut1.r_cnt = 32'hFFFF_FFFE;
        #1;
        release dut1.r_cnt;
        for (int t = 0; t < 3; t++) send1(tmp);
        idle_cycle();
        chk("cnt_saturate", bus1.rnd_cnt, 32'hFFFF_FFFF);
        drain();
`endif

        idle_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/masked_logic_hpc3_vec.md
Name: masked_logic_hpc3_vec

Overview:
- Vector of W lanes, each a first-order-or-higher HPC3-masked 2-input Boolean gate.
- The operation is selectable per transaction: AND, NAND, OR or NOR.
- Adds valid tracking, an optional extra output pipeline stage and clock-enabled registers.
- Used as the generic nonlinear layer for masked S-box datapaths; replaces the per-gate fixed-function HPC3 wrappers.

Parameters:
- SECURITY_ORDER, 1, masking order d; each variable has d+1 shares.
- WIDTH, 1, number of independent lanes W.
- PIPELINE, 0, 1 adds an output register stage (latency 2); 0 gives latency 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  transaction accepted this cycle when high.
- op  in  2  unmasked operation select: 00 AND, 01 NAND, 10 OR, 11 NOR.
- a  in  W*(d+1)  shared operand A; lane l share j at bit l*(d+1)+j.
- b  in  W*(d+1)  shared operand B, same layout as a.
- r  in  W*d*(d+1)  fresh randomness; lane l uses the slice starting at l*d*(d+1).
- out_valid  out  1  result valid.
- c  out  W*(d+1)  shared result, same layout as a.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, c=0, all share registers, op registers and valid registers cleared immediately. A transaction in flight is dropped and never produces out_valid.
- Randomness per lane: H = d(d+1)/2. Unordered pairs (i<j) are enumerated row-major: (0,1),(0,2)..(0,d),(1,2).. giving index k.
  - r_ij = r_ji = r[base+k]
  - r'_ij = r'_ji = r[base+H+k]
- Per lane, per share i, with a', b' the pre-inverted operands:
  - c_i = Reg(a'_i b'_i) XOR sum over j≠i of [ Reg(a'_i(b'_j XOR r_ij)) XOR Reg(~a'_i r_ij XOR r'_ij) ].
  - Every product term is registered before any XOR.
  - The XOR compression after the registers is combinational (PIPELINE=0) or registered (PIPELINE=1).
- Op mapping, by complementing share 0 only (other shares untouched):
  - OR/NOR: a'_0 = ~a_0 and b'_0 = ~b_0. Otherwise a' = a, b' = b.
  - NAND/OR: share 0 of the result is complemented.
  - op is registered alongside the data so the output inversion matches its own transaction.
- Register enables:
  - First-stage registers load only when in_valid=1; otherwise they hold.
  - With PIPELINE=1, second-stage registers load only when stage-1 valid=1.
  - c therefore holds its last value while idle.
- Latency: out_valid asserted exactly 1+PIPELINE cycles after the in_valid cycle.
- Throughput: one transaction per cycle; back-to-back in_valid produces back-to-back out_valid. There is no backpressure.
- Inputs a, b, r and op are sampled only in the in_valid cycle and need not be held afterwards.
- r must be fresh for every accepted transaction. The block does not check this.
- Glitch/security rule: no combinational path mixes different shares of a or b before the first register stage.

Optional Feature:
- Macro: MASKED_LOGIC_RND_CNT_EN.
- Defined:
  - Adds output port rnd_cnt (32 bits).
  - Counts accepted transactions (in_valid=1), saturating at 0xFFFFFFFF.
  - Cleared by rst_n.
  - Used by the TRNG budget monitor.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- d=1, W=1, PIPELINE=0, op=00, a=(1,0), b=(1,1), r=1, r'=0, in_valid pulse -> next cycle out_valid=1, c shares=(1,1), unmasked 0.
- Same inputs, op=01 -> c shares=(0,1), unmasked 1. Repeat with op=10 and 11 -> unmasked results 1 and 0.
- d=2, W=4, PIPELINE=1: 200 random transactions with random ops and fresh random r, in_valid every cycle -> out_valid exactly 2 cycles later each time. Unmasked c equals the reference gate per lane; no gaps.
- in_valid low for 5 cycles after a transaction -> out_valid=0 and c unchanged from last result.
- rst_n asserted mid-flight with PIPELINE=1, one cycle after an in_valid -> c=0 and out_valid=0 immediately. No out_valid after release.
- With MASKED_LOGIC_RND_CNT_EN, 7 accepted and 3 idle cycles -> rst_cnt reads 7. Force the counter to 0xFFFFFFFE, accept 3 -> reads 0xFFFFFFFF.
